bus_wait_shim: RTL and testbench

Parametrised wait-state injector placed between a naive_mips bus master port (ibus or dbus) and a zero-latency memory model (prog_rom / mem).
- Holds each master request for a programmable number of wait cycles, either fixed or LFSR-randomised.
- Issues exactly one memory strobe per transaction and returns registered read data.
- Flags master protocol violations on a sticky error output.
- Replaces ad-hoc wait-state processes in benches and is synthesizable for FPGA bring-up.

---
 rtl/bus_wait_shim.sv | 205 ++++++++++++++++++++
 tb/tb_bus_wait_shim.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_shim.sv
// bus_wait_shim
// -------------
// Wait-state injector that sits between a naive_mips bus master port (ibus
// or dbus) and a zero-latency memory model. Every accepted request is held
// for N wait cycles, then exactly one memory strobe is issued and read data
// is registered back to the master. N is fixed per direction (READ_WAIT /
// WRITE_WAIT) or drawn from a 16-bit LFSR (WAIT_MODE = 1). Master protocol
// violations raise a sticky proto_err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_address         master address
//   m_byteenable      master byte enables
//   m_read, m_write   master request (exactly one may be high)
//   m_wrdata          master write data
//   m_rddata          registered read data, valid when m_stall drops in DONE
//   m_stall           stall to master (combinational)
//   s_address         latched address to memory
//   s_byteenable      latched byte enables to memory
//   s_read, s_write   one-cycle memory strobes, only in ACCESS
//   s_wrdata          latched write data to memory
//   s_rddata          combinational memory read data
//   proto_err         sticky protocol-violation flag, cleared by rst only
//
// Optional build macro:
//   WAIT_STATS_EN     adds stat_txn_count and stat_stall_cycles counters

`timescale 1ns/1ps

module bus_wait_shim #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          READ_WAIT  = 4,
  parameter int          WRITE_WAIT = 1,
  parameter int          WAIT_MODE  = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m_address,
  input  logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic                    m_read,
  input  logic                    m_write,
  input  logic [DATA_WIDTH-1:0]   m_wrdata,
  output logic [DATA_WIDTH-1:0]   m_rddata,
  output logic                    m_stall,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_WIDTH-1:0]   s_wrdata,
  input  logic [DATA_WIDTH-1:0]   s_rddata,
`ifdef WAIT_STATS_EN
  output logic [31:0]             stat_txn_count,
  output logic [31:0]             stat_stall_cycles,
`endif
  output logic                    proto_err
);

  localparam logic [7:0] READ_N  = 8'(READ_WAIT);
  localparam logic [7:0] WRITE_N = 8'(WRITE_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  counter;
  logic [7:0]  next_counter;
  logic [7:0]  wait_n;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        kind_write;
  logic        accept;
  logic        set_err;
  logic        req_match;
  logic        access_ok;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting left; feedback
  // enters at bit 0.
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Wait count for the request being accepted this cycle. In random mode
  // the draw is the current LFSR low nibble, before it steps.
  always_comb begin
    wait_n = READ_N;
    if (WAIT_MODE != 0) begin
      wait_n = {4'b0000, lfsr[3:0]};
    end else if (m_write) begin
      wait_n = WRITE_N;
    end
  end

  // While a transaction is in flight the master must keep presenting the
  // same single request kind at the same address.
  assign req_match = (kind_write ? (m_write & ~m_read) : (m_read & ~m_write)) &&
                     (m_address == s_address);

  // A strobe fires only in a clean ACCESS cycle; a violation or a reset in
  // that cycle suppresses it.
  assign access_ok = (state == ACCESS) && req_match && !rst;

  assign s_read  = access_ok && !kind_write;
  assign s_write = access_ok &&  kind_write;
  assign m_stall = (m_read | m_write) && (state != DONE);

  // Next-state logic.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    accept       = 1'b0;
    set_err      = 1'b0;
    case (state)
      IDLE: begin
        if (m_read && m_write) begin
          set_err = 1'b1;
        end else if (m_read || m_write) begin
          accept       = 1'b1;
          next_counter = wait_n;
          next_state   = (wait_n != 8'd0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!req_match) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end else begin
          next_counter = counter - 8'd1;
          if (counter <= 8'd1) begin
            next_state = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!req_match) begin
          set_err    = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, request latches, read-data capture and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= 8'd0;
      lfsr         <= LFSR_SEED;
      kind_write   <= 1'b0;
      s_address    <= '0;
      s_byteenable <= '0;
      s_wrdata     <= '0;
      m_rddata     <= '0;
      proto_err    <= 1'b0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
      if (set_err) begin
        proto_err <= 1'b1;
      end
      if (accept) begin
        s_address    <= m_address;
        s_byteenable <= m_byteenable;
        s_wrdata     <= m_wrdata;
        kind_write   <= m_write;
        if (WAIT_MODE != 0) begin
          lfsr <= lfsr_next;
        end
      end
      if (s_read) begin
        m_rddata <= s_rddata;
      end
    end
  end

`ifdef WAIT_STATS_EN
  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_txn_count    <= 32'd0;
      stat_stall_cycles <= 32'd0;
    end else begin
      if (state == DONE) begin
        stat_txn_count <= stat_txn_count + 32'd1;
      end
      if (m_stall) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_wait_shim.sv
// Self-checking bench for bus_wait_shim. Three instances are exercised:
//   dut 0: fixed waits, READ_WAIT=4, WRITE_WAIT=0
//   dut 1: random waits from the LFSR (seed 16'hACE1)
//   dut 2: fixed waits, READ_WAIT=2, WRITE_WAIT=1 (statistics when enabled)
// A transaction-level model predicts every output per cycle from the
// request start, the wait count and any injected violation.

`timescale 1ns/1ps

module tb_bus_wait_shim;

  localparam int NDUT = 3;

  logic clk = 1'b0;

  // Free-running 10 ns clock shared by every instance.
  always #5 clk = ~clk;

  logic        rst          [NDUT];
  logic [31:0] m_address    [NDUT];
  logic [3:0]  m_byteenable [NDUT];
  logic        m_read       [NDUT];
  logic        m_write      [NDUT];
  logic [31:0] m_wrdata     [NDUT];
  logic [31:0] m_rddata     [NDUT];
  logic        m_stall      [NDUT];
  logic [31:0] s_address    [NDUT];
  logic [3:0]  s_byteenable [NDUT];
  logic        s_read       [NDUT];
  logic        s_write      [NDUT];
  logic [31:0] s_wrdata     [NDUT];
  logic [31:0] s_rddata     [NDUT];
  logic        proto_err    [NDUT];
`ifdef WAIT_STATS_EN
  logic [31:0] stat_txn_count    [NDUT];
  logic [31:0] stat_stall_cycles [NDUT];
`endif

  // Model state: what every output must show in the current cycle.
  logic        expStall  [NDUT];
  logic        expSRead  [NDUT];
  logic        expSWrite [NDUT];
  logic        expPerr   [NDUT];
  logic [31:0] expRdData [NDUT];
  logic [31:0] expSAddr  [NDUT];
  logic [31:0] expSWData [NDUT];
  logic [3:0]  expSBe    [NDUT];
  bit          chk       [NDUT];

  int total = 0;
  int bad   = 0;

  // Zero-latency memory contents as a pure function of the address.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h3C01_1234;
    return (a * 32'd3) ^ 32'hA5A5_0000;
  endfunction

  // Reference LFSR: x^16+x^14+x^13+x^11+1, Fibonacci, shifting left.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign s_rddata[0] = memRead(s_address[0]);
  assign s_rddata[1] = memRead(s_address[1]);
  assign s_rddata[2] = memRead(s_address[2]);

  bus_wait_shim #(.READ_WAIT(4), .WRITE_WAIT(0), .WAIT_MODE(0)) dut0 (
    .clk(clk), .rst(rst[0]),
    .m_address(m_address[0]), .m_byteenable(m_byteenable[0]),
    .m_read(m_read[0]), .m_write(m_write[0]), .m_wrdata(m_wrdata[0]),
    .m_rddata(m_rddata[0]), .m_stall(m_stall[0]),
    .s_address(s_address[0]), .s_byteenable(s_byteenable[0]),
    .s_read(s_read[0]), .s_write(s_write[0]), .s_wrdata(s_wrdata[0]),
    .s_rddata(s_rddata[0]),
`ifdef WAIT_STATS_EN
    .stat_txn_count(stat_txn_count[0]), .stat_stall_cycles(stat_stall_cycles[0]),
`endif
    .proto_err(proto_err[0])
  );

  bus_wait_shim #(.READ_WAIT(4), .WRITE_WAIT(1), .WAIT_MODE(1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst[1]),
    .m_address(m_address[1]), .m_byteenable(m_byteenable[1]),
    .m_read(m_read[1]), .m_write(m_write[1]), .m_wrdata(m_wrdata[1]),
    .m_rddata(m_rddata[1]), .m_stall(m_stall[1]),
    .s_address(s_address[1]), .s_byteenable(s_byteenable[1]),
    .s_read(s_read[1]), .s_write(s_write[1]), .s_wrdata(s_wrdata[1]),
    .s_rddata(s_rddata[1]),
`ifdef WAIT_STATS_EN
    .stat_txn_count(stat_txn_count[1]), .stat_stall_cycles(stat_stall_cycles[1]),
`endif
    .proto_err(proto_err[1])
  );

  bus_wait_shim #(.READ_WAIT(2), .WRITE_WAIT(1), .WAIT_MODE(0)) dut2 (
    .clk(clk), .rst(rst[2]),
    .m_address(m_address[2]), .m_byteenable(m_byteenable[2]),
    .m_read(m_read[2]), .m_write(m_write[2]), .m_wrdata(m_wrdata[2]),
    .m_rddata(m_rddata[2]), .m_stall(m_stall[2]),
    .s_address(s_address[2]), .s_byteenable(s_byteenable[2]),
    .s_read(s_read[2]), .s_write(s_write[2]), .s_wrdata(s_wrdata[2]),
    .s_rddata(s_rddata[2]),
`ifdef WAIT_STATS_EN
    .stat_txn_count(stat_txn_count[2]), .stat_stall_cycles(stat_stall_cycles[2]),
`endif
    .proto_err(proto_err[2])
  );

  // One comparison: counts it, reports it on mismatch.
  task automatic checkField(input string name, input int d, input logic [31:0] act,
                            input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s dut%0d: got %0h want %0h", name, d, act, expv);
    end
  endtask

  // Compare every observable output of one instance against the model.
  task automatic checkOutput(input int d);
    checkField("m_stall",      d, 32'(m_stall[d]),      32'(expStall[d]));
    checkField("s_read",       d, 32'(s_read[d]),       32'(expSRead[d]));
    checkField("s_write",      d, 32'(s_write[d]),      32'(expSWrite[d]));
    checkField("proto_err",    d, 32'(proto_err[d]),    32'(expPerr[d]));
    checkField("m_rddata",     d, m_rddata[d],          expRdData[d]);
    checkField("s_address",    d, s_address[d],         expSAddr[d]);
    checkField("s_wrdata",     d, s_wrdata[d],          expSWData[d]);
    checkField("s_byteenable", d, 32'(s_byteenable[d]), 32'(expSBe[d]));
  endtask

  // Compare process: outputs are sampled on the falling edge, half a cycle
  // away from the edge that updates them.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (chk[d]) checkOutput(d);
    end
  end

  task automatic resetModel(input int d);
    expStall[d]  = 1'b0;
    expSRead[d]  = 1'b0;
    expSWrite[d] = 1'b0;
    expPerr[d]   = 1'b0;
    expRdData[d] = 32'h0;
    expSAddr[d]  = 32'h0;
    expSWData[d] = 32'h0;
    expSBe[d]    = 4'h0;
  endtask

  // Master goes quiet for cnt cycles.
  task automatic idleCycles(input int d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      m_read[d]    = 1'b0;
      m_write[d]   = 1'b0;
      expStall[d]  = 1'b0;
      expSRead[d]  = 1'b0;
      expSWrite[d] = 1'b0;
    end
  endtask

  // One master transaction with n wait cycles. Cycle k=0 is the accept
  // cycle, k=n+1 the strobe cycle, k=n+2 the completion cycle.
  // vkind: 0 clean, 1 request dropped at cycle vk, 2 address changed at
  // cycle vk, 3 rst pulsed at cycle vk. Returns the measured stall cycles,
  // the first strobe cycle (-1 if none) and the strobe count.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wd,
                               input int n, input int vkind, input int vk,
                               output int stallCnt, output int strobeCyc,
                               output int strobeCnt);
    stallCnt  = 0;
    strobeCyc = -1;
    strobeCnt = 0;
    for (int k = 0; k <= n + 2; k++) begin
      @(posedge clk); #1;
      m_address[d]    = addr;
      m_byteenable[d] = be;
      m_wrdata[d]     = wd;
      m_read[d]       = !wr;
      m_write[d]      = wr;
      if (k == 1) begin
        expSAddr[d]  = addr;
        expSBe[d]    = be;
        expSWData[d] = wd;
      end
      expStall[d]  = (k <= n + 1);
      expSRead[d]  = !wr && (k == n + 1);
      expSWrite[d] = wr && (k == n + 1);
      if (k == n + 2 && !wr) expRdData[d] = memRead(addr);
      if (vkind != 0 && k == vk) begin
        expSRead[d]  = 1'b0;
        expSWrite[d] = 1'b0;
        case (vkind)
          1: begin
            m_read[d]   = 1'b0;
            m_write[d]  = 1'b0;
            expStall[d] = 1'b0;
          end
          2: m_address[d] = addr + 32'd4;
          default: rst[d] = 1'b1;
        endcase
      end
      @(negedge clk);
      if (m_stall[d]) stallCnt++;
      if (s_read[d] || s_write[d]) begin
        strobeCnt++;
        if (strobeCyc < 0) strobeCyc = k;
      end
      if (vkind != 0 && k == vk) begin
        @(posedge clk); #1;
        m_read[d]  = 1'b0;
        m_write[d] = 1'b0;
        if (vkind == 3) begin
          rst[d] = 1'b0;
          resetModel(d);
        end else begin
          expPerr[d]   = 1'b1;
          expStall[d]  = 1'b0;
          expSRead[d]  = 1'b0;
          expSWrite[d] = 1'b0;
        end
        @(negedge clk);
        break;
      end
    end
  endtask

  // Both request lines high in IDLE: stalls that cycle, no accept, error.
  task automatic bothHigh(input int d);
    @(posedge clk); #1;
    m_read[d]    = 1'b1;
    m_write[d]   = 1'b1;
    expStall[d]  = 1'b1;
    expSRead[d]  = 1'b0;
    expSWrite[d] = 1'b0;
    @(posedge clk); #1;
    m_read[d]   = 1'b0;
    m_write[d]  = 1'b0;
    expStall[d] = 1'b0;
    expPerr[d]  = 1'b1;
    @(negedge clk);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running want finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed test sequence.
  initial begin
    int sc, scyc, scnt;
    int stallB [8];
    logic [15:0] refLfsr;
    int n, i;
    bit seenZero;

    for (int d = 0; d < NDUT; d++) begin
      rst[d]          = 1'b1;
      m_address[d]    = 32'h0;
      m_byteenable[d] = 4'h0;
      m_read[d]       = 1'b0;
      m_write[d]      = 1'b0;
      m_wrdata[d]     = 32'h0;
      chk[d]          = 1'b0;
      resetModel(d);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b0;
      chk[d] = 1'b1;
    end
    @(negedge clk);
    checkField("reset_rddata", 0, m_rddata[0], 32'h0);
    checkField("reset_perr",   0, 32'(proto_err[0]), 32'h0);
    checkField("reset_stall",  0, 32'(m_stall[0]), 32'h0);

    // dut2: three back-to-back reads with two waits each.
    for (int t = 0; t < 3; t++) begin
      applyStimulus(2, 1'b0, 32'h0000_0500 + 32'(4 * t), 4'hF, 32'h0, 2, 0, 0, sc, scyc, scnt);
      checkField("stats_rd_stall", 2, 32'(sc), 32'd4);
    end
    idleCycles(2, 1);
    @(negedge clk);
`ifdef WAIT_STATS_EN
    checkField("stat_txn_count",    2, stat_txn_count[2],    32'd3);
    checkField("stat_stall_cycles", 2, stat_stall_cycles[2], 32'd12);
`endif
    applyStimulus(2, 1'b1, 32'h0000_0600, 4'b1100, 32'h1234_5678, 1, 0, 0, sc, scyc, scnt);
    checkField("wr1_stall",  2, 32'(sc), 32'd3);
    checkField("wr1_strobe", 2, 32'(scyc), 32'd2);
    idleCycles(2, 1);
    // Address changes in the ACCESS cycle: strobe suppressed, error set.
    applyStimulus(2, 1'b0, 32'h0000_0700, 4'hF, 32'h0, 2, 2, 3, sc, scyc, scnt);
    checkField("addr_chg_strobes", 2, 32'(scnt), 32'd0);
    checkField("addr_chg_perr",    2, 32'(proto_err[2]), 32'd1);
    idleCycles(2, 1);

    // dut0: fixed four-wait read.
    applyStimulus(0, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 4, 0, 0, sc, scyc, scnt);
    checkField("rd_stall_cycles", 0, 32'(sc), 32'd6);
    checkField("rd_strobe_cycle", 0, 32'(scyc), 32'd5);
    checkField("rd_strobe_count", 0, 32'(scnt), 32'd1);
    checkField("rd_data",         0, m_rddata[0], 32'h3C01_1234);
    idleCycles(0, 1);

    // dut0: zero-wait write.
    applyStimulus(0, 1'b1, 32'h0000_2000, 4'b0011, 32'hDEAD_BEEF, 0, 0, 0, sc, scyc, scnt);
    checkField("wr_stall_cycles", 0, 32'(sc), 32'd2);
    checkField("wr_strobe_cycle", 0, 32'(scyc), 32'd1);
    checkField("wr_strobe_count", 0, 32'(scnt), 32'd1);
    checkField("wr_data_latched", 0, s_wrdata[0], 32'hDEAD_BEEF);
    checkField("wr_be_latched",   0, 32'(s_byteenable[0]), 32'h3);
    checkField("wr_rddata_kept",  0, m_rddata[0], 32'h3C01_1234);
    idleCycles(0, 1);

    // dut0: read dropped in the second WAIT cycle, then ten clean reads.
    applyStimulus(0, 1'b0, 32'h0000_3000, 4'hF, 32'h0, 4, 1, 2, sc, scyc, scnt);
    checkField("drop_strobes", 0, 32'(scnt), 32'd0);
    checkField("drop_perr",    0, 32'(proto_err[0]), 32'd1);
    for (int t = 0; t < 10; t++) begin
      applyStimulus(0, 1'b0, 32'h0000_4000 + 32'(4 * t), 4'hF, 32'h0, 4, 0, 0, sc, scyc, scnt);
      checkField("post_err_stall", 0, 32'(sc), 32'd6);
    end
    checkField("perr_sticky", 0, 32'(proto_err[0]), 32'd1);
    idleCycles(0, 1);

    // dut0: rst pulsed during WAIT, then a full-latency read.
    applyStimulus(0, 1'b0, 32'h0000_5000, 4'hF, 32'h0, 4, 3, 2, sc, scyc, scnt);
    checkField("rst_strobes", 0, 32'(scnt), 32'd0);
    checkField("rst_rddata",  0, m_rddata[0], 32'h0);
    checkField("rst_perr",    0, 32'(proto_err[0]), 32'd0);
    checkField("rst_saddr",   0, s_address[0], 32'h0);
    applyStimulus(0, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 4, 0, 0, sc, scyc, scnt);
    checkField("after_rst_stall", 0, 32'(sc), 32'd6);
    checkField("after_rst_data",  0, m_rddata[0], 32'h3C01_1234);
    idleCycles(0, 1);

    // dut1: random waits, reads until at least 8 done and an N=0 draw seen.
    refLfsr  = 16'hACE1;
    i        = 0;
    seenZero = 1'b0;
    while ((i < 8 || !seenZero) && i < 200) begin
      n       = int'(refLfsr[3:0]);
      refLfsr = lfsrNext(refLfsr);
      applyStimulus(1, 1'b0, 32'h0000_0100 + 32'(4 * i), 4'hF, 32'h0, n, 0, 0, sc, scyc, scnt);
      checkField("rand_stall", 1, 32'(sc), 32'(n + 2));
      if (i < 8) stallB[i] = sc;
      if (n == 0) seenZero = 1'b1;
      i++;
    end
    if (!seenZero) $display("[TB] note: no zero-wait draw within %0d reads", i);
    checkField("rand_stall_0", 1, 32'(stallB[0]), 32'd3);
    checkField("rand_stall_1", 1, 32'(stallB[1]), 32'd5);
    checkField("rand_stall_2", 1, 32'(stallB[2]), 32'd9);
    checkField("rand_stall_3", 1, 32'(stallB[3]), 32'd17);
    checkField("rand_stall_7", 1, 32'(stallB[7]), 32'd4);
    idleCycles(1, 1);

    // dut1: both request lines high in IDLE.
    bothHigh(1);
    checkField("both_high_perr", 1, 32'(proto_err[1]), 32'd1);
    idleCycles(1, 2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
